vdc_host_master: RTL

- CPU-side bus initiator for the epochtv1 host port. Drives A/DB/RDB/WRB/CSB with programmable setup/strobe/hold timing.
- Accepts single or burst read/write requests from a bench or loader over a request/acknowledge handshake.
- Used to load VRAM and registers, and to read them back, in simulation and in the core's ROM/state loader.
- Bursts auto-increment the address (optional) and repeat the write data, which gives a fill operation.

---
 rtl/vdc_host_pkg.sv | 26 ++
 rtl/vdc_host_master_if.sv | 34 +++
 rtl/vdc_host_phase_timer.sv | 23 ++
 rtl/vdc_host_master.sv | 125 ++++++++++++
 4 files changed

// File: rtl/vdc_host_pkg.sv
// Shared types and widths for the epochtv1 host-port bus initiator.
package vdc_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 13;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Phase-counter width needed to hold the longest configured phase.
  function automatic int tick_w(input int max_ticks);
    return (max_ticks <= 1) ? 1 : $clog2(max_ticks + 1);
  endfunction

endpackage

// File: rtl/vdc_host_master_if.sv
// Request/acknowledge handshake and host-port bus signals of the bus initiator.
interface vdc_host_master_if;
  import vdc_host_pkg::*;

  logic              REQ;
  logic              REQ_WR;
  logic [ADDR_W-1:0] REQ_A;
  logic [DATA_W-1:0] REQ_D;
  logic [LEN_W-1:0]  REQ_LEN;
  logic              REQ_INC;
  logic              ACK;
  logic              BUSY;
  logic              DONE;
  logic              RD_VALID;
  logic [DATA_W-1:0] RD_DATA;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] DB_O;
  logic              DB_OE;
  logic [DATA_W-1:0] DB_I;
  logic              RDB;
  logic              WRB;
  logic              CSB;

  modport master (
    input  REQ, REQ_WR, REQ_A, REQ_D, REQ_LEN, REQ_INC, DB_I,
    output ACK, BUSY, DONE, RD_VALID, RD_DATA, A, DB_O, DB_OE, RDB, WRB, CSB
  );

  modport slave (
    output REQ, REQ_WR, REQ_A, REQ_D, REQ_LEN, REQ_INC, DB_I,
    input  ACK, BUSY, DONE, RD_VALID, RD_DATA, A, DB_O, DB_OE, RDB, WRB, CSB
  );

endinterface

// File: rtl/vdc_host_phase_timer.sv
// Counts CE ticks within the current bus phase and flags the final one.
module vdc_host_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         clr,
  input  logic [W-1:0] len,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (ce)    cnt <= cnt + W'(1);
  end

  // A zero-length phase reports its end immediately so it can never stall.
  assign last = (len == '0) || (cnt >= len - W'(1));

endmodule

// File: rtl/vdc_host_master.sv
// CPU-side initiator for the epochtv1 host port: single/burst accesses with
// programmable setup/strobe/hold timing, all advance gated by CE.
module vdc_host_master #(
  parameter int SETUP_TICKS  = 1,
  parameter int STROBE_TICKS = 2,
  parameter int HOLD_TICKS   = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CE,
  vdc_host_master_if.master bus
);
  import vdc_host_pkg::*;

  localparam int     TICK_W = tick_w(max3(SETUP_TICKS, STROBE_TICKS, HOLD_TICKS));
  localparam state_t FIRST  = (SETUP_TICKS > 0) ? ST_SETUP : ST_STROBE;

  state_t            st;
  logic              wr;
  logic              inc;
  logic [LEN_W-1:0]  remaining;
  logic [TICK_W-1:0] phase_len;
  logic              last;
  logic              phase_end;
  logic              beat_end;

  always_comb begin
    phase_len = '0;
    case (st)
      ST_SETUP:  phase_len = TICK_W'(SETUP_TICKS);
      ST_STROBE: phase_len = TICK_W'(STROBE_TICKS);
      ST_HOLD:   phase_len = TICK_W'(HOLD_TICKS);
      default:   phase_len = '0;
    endcase
  end

  assign phase_end = CE && last && (st != ST_IDLE);
  assign beat_end  = phase_end && ((st == ST_HOLD) || (st == ST_STROBE && HOLD_TICKS == 0));

  vdc_host_phase_timer #(.W(TICK_W)) u_timer (
    .clk  (CLK),
    .rst  (RESET),
    .ce   (CE),
    .clr  ((st == ST_IDLE) || phase_end),
    .len  (phase_len),
    .last (last)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st           <= ST_IDLE;
      wr           <= 1'b0;
      inc          <= 1'b0;
      remaining    <= '0;
      bus.ACK      <= 1'b0;
      bus.BUSY     <= 1'b0;
      bus.DONE     <= 1'b0;
      bus.RD_VALID <= 1'b0;
      bus.RD_DATA  <= '0;
      bus.A        <= '0;
      bus.DB_O     <= '0;
      bus.DB_OE    <= 1'b0;
      bus.RDB      <= 1'b1;
      bus.WRB      <= 1'b1;
      bus.CSB      <= 1'b1;
    end else begin
      bus.ACK      <= 1'b0;
      bus.DONE     <= 1'b0;
      bus.RD_VALID <= 1'b0;
      case (st)
        // Acceptance is not gated by CE.
        ST_IDLE: if (bus.REQ) begin
          bus.ACK   <= 1'b1;
          bus.BUSY  <= 1'b1;
          bus.CSB   <= 1'b0;
          wr        <= bus.REQ_WR;
          inc       <= bus.REQ_INC;
          bus.A     <= bus.REQ_A;
          bus.DB_O  <= bus.REQ_D;
          bus.DB_OE <= bus.REQ_WR;
          remaining <= (bus.REQ_LEN == '0) ? LEN_W'(1) : bus.REQ_LEN;
          st        <= FIRST;
          bus.RDB   <= !(FIRST == ST_STROBE && !bus.REQ_WR);
          bus.WRB   <= !(FIRST == ST_STROBE && bus.REQ_WR);
        end
        ST_SETUP: if (phase_end) begin
          st      <= ST_STROBE;
          bus.RDB <= wr;
          bus.WRB <= !wr;
        end
        ST_STROBE: if (phase_end) begin
          if (!wr) begin
            bus.RD_DATA  <= bus.DB_I;
            bus.RD_VALID <= 1'b1;
          end
          st      <= ST_HOLD;
          bus.RDB <= 1'b1;
          bus.WRB <= 1'b1;
        end
        ST_HOLD: ;
        default: st <= ST_IDLE;
      endcase

      // End of a beat overrides the per-phase transition above.
      if (beat_end) begin
        remaining <= remaining - LEN_W'(1);
        if (remaining > LEN_W'(1)) begin
          st      <= FIRST;
          bus.RDB <= !(FIRST == ST_STROBE && !wr);
          bus.WRB <= !(FIRST == ST_STROBE && wr);
          if (inc) bus.A <= bus.A + ADDR_W'(1);
        end else begin
          st        <= ST_IDLE;
          bus.CSB   <= 1'b1;
          bus.RDB   <= 1'b1;
          bus.WRB   <= 1'b1;
          bus.DB_OE <= 1'b0;
          bus.BUSY  <= 1'b0;
          bus.DONE  <= 1'b1;
        end
      end
    end
  end

endmodule
